pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 139 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register between two valid/ready handshakes.
// It can be built as a two-entry skid buffer or as a single register, and it keeps saturating performance counters.
module pipe_stage_reg #(
    parameter int WIDTH   = 161,
    parameter int PC_LSB  = 129,
    parameter int SKID    = 1,
    parameter int KEEP_PC = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    input  logic [31:0]      flush_pc,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic [WIDTH-1:0]   bubble_q, bubble_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   bubbleCnt_q, bubbleCnt_d;
    logic               accept;
    logic               deliver;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
        return (&v) ? v : v + CNT_W'(en);
    endfunction

    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_valid ? main_q : bubble_q;

    // The skid variant derives ready from registered state only, so out_ready never reaches in_ready.
    generate
        if (SKID != 0) begin : g_skidReady
            assign in_ready = ~reset & (state_q != TWO);
        end else begin : g_regReady
            assign in_ready = ~reset & (~out_valid | out_ready);
        end
    endgenerate

    assign accept  = in_valid & in_ready;
    assign deliver = out_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        bubble_d = bubble_q;
        if (flush) begin
            state_d  = EMPTY;
            skid_d   = '0;
            bubble_d = '0;
            if (KEEP_PC != 0) begin
                bubble_d[PC_LSB +: 32] = flush_pc;
            end
        end else if (SKID != 0) begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end else if (deliver) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (deliver) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end else begin
            if (accept) begin
                main_d  = in_data;
                state_d = ONE;
            end else if (deliver) begin
                state_d = EMPTY;
            end
        end
    end

    // Counters look at the pre-edge handshake and keep counting through a flush.
    always_comb begin
        beat_d      = satInc(beat_q, deliver);
        stall_d     = satInc(stall_q, out_valid & ~out_ready);
        bubbleCnt_d = satInc(bubbleCnt_q, ~out_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            bubble_q    <= '0;
            beat_q      <= '0;
            stall_q     <= '0;
            bubbleCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            bubble_q    <= bubble_d;
            beat_q      <= beat_d;
            stall_q     <= stall_d;
            bubbleCnt_q <= bubbleCnt_d;
        end
    end

    assign beat_cnt   = beat_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubbleCnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Two instances share one stimulus stream: a default skid buffer and a single-register stage with 4-bit counters.
// A queue-based reference model for each instance scores every cycle at the falling edge.
module tb_pipe_stage_reg;

    typedef logic [160:0] beat_t;
    localparam int PC_LSB = 129;
    localparam int MAXA   = 65535;
    localparam int MAXB   = 15;

    logic        clk;
    logic        reset;
    logic        inValid;
    beat_t       inData;
    logic        outReady;
    logic        flush;
    logic [31:0] flushPc;

    logic        inReadyA, outValidA;
    beat_t       outDataA;
    logic [15:0] beatCntA, stallCntA, bubbleCntA;
    logic        inReadyB, outValidB;
    beat_t       outDataB;
    logic [3:0]  beatCntB, stallCntB, bubbleCntB;

    int nChecks = 0;
    int nFail   = 0;

    beat_t qA[$];
    beat_t qB[$];
    beat_t bubA = '0;
    beat_t bubB = '0;
    int beatA = 0, stallA = 0, bubCA = 0;
    int beatB = 0, stallB = 0, bubCB = 0;

    pipe_stage_reg dutA (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_data(inData),
        .in_ready(inReadyA), .out_valid(outValidA), .out_data(outDataA),
        .out_ready(outReady), .flush(flush), .flush_pc(flushPc),
        .beat_cnt(beatCntA), .stall_cnt(stallCntA), .bubble_cnt(bubbleCntA)
    );

    pipe_stage_reg #(.SKID(0), .KEEP_PC(0), .CNT_W(4)) dutB (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_data(inData),
        .in_ready(inReadyB), .out_valid(outValidB), .out_data(outDataB),
        .out_ready(outReady), .flush(flush), .flush_pc(flushPc),
        .beat_cnt(beatCntB), .stall_cnt(stallCntB), .bubble_cnt(bubbleCntB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int sat(input int v, input int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    function automatic beat_t randBeat();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[160:0];
    endfunction

    task automatic checkOutput(input string name, input beat_t act, input beat_t exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Score both instances against their models, then advance the models with the inputs the next edge will see.
    always @(negedge clk) begin
        logic expReady, vld, dlv, acc;

        expReady = reset ? 1'b0 : (qA.size() < 2);
        checkOutput("A in_ready", beat_t'(inReadyA), beat_t'(expReady));
        checkOutput("A out_valid", beat_t'(outValidA), beat_t'(qA.size() > 0));
        checkOutput("A out_data", outDataA, (qA.size() > 0) ? qA[0] : bubA);
        checkOutput("A beat_cnt", beat_t'(beatCntA), beat_t'(beatA));
        checkOutput("A stall_cnt", beat_t'(stallCntA), beat_t'(stallA));
        checkOutput("A bubble_cnt", beat_t'(bubbleCntA), beat_t'(bubCA));
        if (reset) begin
            qA.delete();
            bubA = '0;
            beatA = 0; stallA = 0; bubCA = 0;
        end else begin
            vld = (qA.size() > 0);
            dlv = vld && outReady;
            acc = inValid && expReady;
            if (dlv) beatA = sat(beatA, MAXA);
            if (vld && !outReady) stallA = sat(stallA, MAXA);
            if (!vld) bubCA = sat(bubCA, MAXA);
            if (flush) begin
                qA.delete();
                bubA = '0;
                bubA[PC_LSB +: 32] = flushPc;
            end else begin
                if (dlv) void'(qA.pop_front());
                if (acc) qA.push_back(inData);
            end
        end

        expReady = reset ? 1'b0 : ((qB.size() == 0) || outReady);
        checkOutput("B in_ready", beat_t'(inReadyB), beat_t'(expReady));
        checkOutput("B out_valid", beat_t'(outValidB), beat_t'(qB.size() > 0));
        checkOutput("B out_data", outDataB, (qB.size() > 0) ? qB[0] : bubB);
        checkOutput("B beat_cnt", beat_t'(beatCntB), beat_t'(beatB));
        checkOutput("B stall_cnt", beat_t'(stallCntB), beat_t'(stallB));
        checkOutput("B bubble_cnt", beat_t'(bubbleCntB), beat_t'(bubCB));
        if (reset) begin
            qB.delete();
            beatB = 0; stallB = 0; bubCB = 0;
        end else begin
            vld = (qB.size() > 0);
            dlv = vld && outReady;
            acc = inValid && expReady;
            if (dlv) beatB = sat(beatB, MAXB);
            if (vld && !outReady) stallB = sat(stallB, MAXB);
            if (!vld) bubCB = sat(bubCB, MAXB);
            if (flush) begin
                qB.delete();
            end else begin
                if (dlv) void'(qB.pop_front());
                if (acc) qB.push_back(inData);
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic iv, input beat_t d,
                                 input logic ordy, input logic fl, input logic [31:0] fpc);
        reset    = rst;
        inValid  = iv;
        inData   = d;
        outReady = ordy;
        flush    = fl;
        flushPc  = fpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, '0, 0, 0, 32'h0);

        // Streaming three beats with the sink always ready.
        applyStimulus(0, 1, beat_t'(161'hA), 1, 0, 32'h0);
        applyStimulus(0, 1, beat_t'(161'hB), 1, 0, 32'h0);
        applyStimulus(0, 1, beat_t'(161'hC), 1, 0, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 1, 0, 32'h0);

        // Backpressure fills the skid entry, then the sink drains in order.
        applyStimulus(0, 1, beat_t'(161'hA), 0, 0, 32'h0);
        applyStimulus(0, 1, beat_t'(161'hB), 0, 0, 32'h0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 1, 0, 32'h0);

        // Flush with two entries held while a new beat is also offered.
        applyStimulus(0, 1, beat_t'(161'h11), 0, 0, 32'h0);
        applyStimulus(0, 1, beat_t'(161'h22), 0, 0, 32'h0);
        applyStimulus(0, 1, beat_t'(161'h33), 0, 1, 32'h0000_3010);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 1, 0, 32'h0);

        // Long stall to saturate the narrow counters, then reset mid-operation.
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, randBeat(), 0, 0, 32'h0);
        applyStimulus(1, 1, randBeat(), 1, 0, 32'h0);
        applyStimulus(1, 1, randBeat(), 1, 1, 32'hDEAD_BEEF);
        applyStimulus(0, 1, beat_t'(161'h5A), 1, 0, 32'h0);
        applyStimulus(0, 1, beat_t'(161'h6B), 1, 0, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0), $urandom_range(0, 3) != 0, randBeat(),
                          $urandom_range(0, 9) < 7, ($urandom_range(0, 99) < 3), $urandom());
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 1, 0, 32'h0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
